wb_tgt_chk: RTL and testbench
=============================

// Module: wb_tgt_chk
// PURPOSE
//  Synthesizable, parametrised protocol checker for a pipelined Wishbone target port; passive tap, no effect on the bus.
//  Tracks up to MAX_OUTST outstanding accepted requests and flags protocol violations as sticky bits plus a pulse.
//  Adds a watchdog timeout and stall-hold checking.
//  Sits beside any target port of the crossbar; outputs feed a status register or simulation scoreboard.
// PARAMETERS
//  ADR_WIDTH   16  address bus width
//  DAT_WIDTH   16  data bus width
//  SEL_WIDTH   2   data select lines
//  TGA_WIDTH   1   address tag width
//  TGC_WIDTH   1   cycle tag width
//  TGWD_WIDTH  1   write data tag width
//  MAX_OUTST   4   max outstanding requests (>=1); CNT_W=$clog2(MAX_OUTST+1)
//  TIMEOUT     256 cycles with outstanding>0 and no termination before flag; 0 disables watchdog
// PORTS
//  clk_i         in   1          module clock
//  sync_rst_n_i  in   1          synchronous reset, active low
//  clr_i         in   1          clear sticky error flags
//  tgt_cyc_o     in   1          monitored CYC
//  tgt_stb_o     in   1          monitored STB
//  tgt_we_o      in   1          monitored WE
//  tgt_sel_o     in   SEL_WIDTH  monitored SEL
//  tgt_adr_o     in   ADR_WIDTH  monitored ADR
//  tgt_dat_o     in   DAT_WIDTH  monitored write data
//  tgt_tga_o     in   TGA_WIDTH  monitored address tags
//  tgt_tgc_o     in   TGC_WIDTH  monitored cycle tags
//  tgt_tgd_o     in   TGWD_WIDTH monitored write data tags
//  tgt_ack_i     in   1          monitored ACK
//  tgt_err_i     in   1          monitored ERR
//  tgt_rty_i     in   1          monitored RTY
//  tgt_stall_i   in   1          monitored STALL
//  outst_o       out  CNT_W      outstanding request count
//  busy_o        out  1          outst_o != 0
//  err_o         out  7          sticky violation flags (bit map below)
//  err_stb_o     out  1          one-cycle pulse: any violation detected at previous edge
//  err_first_o   out  3          index of first violation since reset/clr (lowest index on tie)
// BEHAVIOUR
//  Reset (sync_rst_n_i=0 at edge): all outputs and internal regs 0; overrides clr_i and all events.
//  req = cyc&stb&~stall; term = ack|err|rty. All outputs registered; flag visible 1 cycle after offending edge.
//  Counter: next = outst + req - (term & outst>0); req&term same cycle -> unchanged. Never exceeds MAX_OUTST or goes below 0.
//  cyc=0: counter cleared to 0 next cycle (cycle abort); watchdog cleared.
//  err_o bits (set condition sampled at edge):
//   [0] CYC_DROP   cyc=0 while outst>0 and no term this cycle
//   [1] MULTI_TERM more than one of ack/err/rty high
//   [2] SPUR_TERM  term with outst=0 (incl. term with cyc=0)
//   [3] OVERFLOW   req & ~term & outst=MAX_OUTST; counter saturates
//   [4] TIMEOUT    watchdog reaches TIMEOUT; fires once, re-armed by term or outst=0
//   [5] STB_NO_CYC stb=1 while cyc=0
//   [6] STALL_HOLD prev cycle cyc&stb&stall, this cycle cyc=1 and (stb=0 or we/sel/adr/tga/tgc changed,
//                  or we=1 and dat/tgd changed); held copy captured each stalled cycle
//  Watchdog: TO_W-bit counter, +1 per cycle with outst>0 & ~term, cleared on term or outst=0, holds at TIMEOUT.
//  Sticky: err_o |= new; clr_i clears err_o/err_first_o, but a violation in the same cycle wins (set, recorded first).
//  err_first_o loads only when err_o was 0; err_stb_o = |new, independent of clr_i.
//  Multiple violations same edge: all bits set, one err_stb_o pulse.
// TESTING
//  Reset, 3 pipelined reads no stall, acks on cycles 2..4 -> outst_o 1,2,2,1,0; err_o=0.
//  MAX_OUTST=4: 5 reqs no term -> err_o[3]=1, err_stb_o 1 cycle, outst_o holds 4, err_first_o=3.
//  cyc drop with outst_o=2 -> err_o[0]=1, outst_o=0 next cycle; ack+err together -> err_o[1]=1.
//  TIMEOUT=8: 1 req, no term for 8 cycles -> err_o[4] after 8th cycle, single pulse; ack re-arms.
//  stb&stall then adr 0x10->0x14 while stalled -> err_o[6]=1; unchanged adr -> no flag.
//  clr_i with concurrent STB_NO_CYC -> err_o=0x20, err_first_o=5; reset mid-burst -> all 0 next cycle.

Source files
------------

// File: rtl/wb_tgt_chk_if.sv
// wb_tgt_chk_if: pipelined Wishbone target-port signal bundle.
//   master : drives cyc/stb/we/sel/adr/dat/tga/tgc/tgd, samples ack/err/rty/stall
//   slave  : the target side, mirror of master
//   mon    : passive tap, every signal is an input
interface wb_tgt_chk_if #(
    parameter int ADR_WIDTH  = 16,
    parameter int DAT_WIDTH  = 16,
    parameter int SEL_WIDTH  = 2,
    parameter int TGA_WIDTH  = 1,
    parameter int TGC_WIDTH  = 1,
    parameter int TGWD_WIDTH = 1
);
    logic                  tgt_cyc_o;
    logic                  tgt_stb_o;
    logic                  tgt_we_o;
    logic [SEL_WIDTH-1:0]  tgt_sel_o;
    logic [ADR_WIDTH-1:0]  tgt_adr_o;
    logic [DAT_WIDTH-1:0]  tgt_dat_o;
    logic [TGA_WIDTH-1:0]  tgt_tga_o;
    logic [TGC_WIDTH-1:0]  tgt_tgc_o;
    logic [TGWD_WIDTH-1:0] tgt_tgd_o;
    logic                  tgt_ack_i;
    logic                  tgt_err_i;
    logic                  tgt_rty_i;
    logic                  tgt_stall_i;

    modport master (
        output tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_sel_o, tgt_adr_o, tgt_dat_o,
               tgt_tga_o, tgt_tgc_o, tgt_tgd_o,
        input  tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i
    );

    modport slave (
        input  tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_sel_o, tgt_adr_o, tgt_dat_o,
               tgt_tga_o, tgt_tgc_o, tgt_tgd_o,
        output tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i
    );

    modport mon (
        input tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_sel_o, tgt_adr_o, tgt_dat_o,
              tgt_tga_o, tgt_tgc_o, tgt_tgd_o,
              tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i
    );
endinterface

// File: rtl/wb_tgt_chk.sv
// wb_tgt_chk: passive protocol checker for a pipelined Wishbone target port.
//   clk_i, sync_rst_n_i : clock, synchronous active-low reset
//   clr_i               : clear sticky flags (a same-cycle violation still wins)
//   bus                 : monitored target port (mon modport, inputs only)
//   outst_o / busy_o    : outstanding accepted-request count / count non-zero
//   err_o               : sticky flags {STALL_HOLD,STB_NO_CYC,TIMEOUT,OVERFLOW,SPUR_TERM,MULTI_TERM,CYC_DROP}
//   err_stb_o           : one-cycle pulse when any violation was seen at the previous edge
//   err_first_o         : index of the first violation since reset/clear
module wb_tgt_chk #(
    parameter  int ADR_WIDTH  = 16,
    parameter  int DAT_WIDTH  = 16,
    parameter  int SEL_WIDTH  = 2,
    parameter  int TGA_WIDTH  = 1,
    parameter  int TGC_WIDTH  = 1,
    parameter  int TGWD_WIDTH = 1,
    parameter  int MAX_OUTST  = 4,
    parameter  int TIMEOUT    = 256,
    localparam int CNT_W      = $clog2(MAX_OUTST + 1)
) (
    input  logic             clk_i,
    input  logic             sync_rst_n_i,
    input  logic             clr_i,
    wb_tgt_chk_if.mon        bus,
    output logic [CNT_W-1:0] outst_o,
    output logic             busy_o,
    output logic [6:0]       err_o,
    output logic             err_stb_o,
    output logic [2:0]       err_first_o
);
    localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int CTL_W = 1 + SEL_WIDTH + ADR_WIDTH + TGA_WIDTH + TGC_WIDTH;
    localparam int WD_W  = DAT_WIDTH + TGWD_WIDTH;

    logic [CNT_W-1:0] outst_q, outst_d;
    logic [TO_W-1:0]  wd_q, wd_d;
    logic [6:0]       err_q, err_d;
    logic             err_stb_q, err_stb_d;
    logic [2:0]       first_q, first_d;
    logic             stalled_q, stalled_d;
    logic [CTL_W-1:0] ctl_q, ctl_d;
    logic [WD_W-1:0]  wdat_q, wdat_d;

    logic             req, term, has, at_max, dec, wd_run;
    logic [CTL_W-1:0] ctl;
    logic [WD_W-1:0]  wdat;
    logic [6:0]       new_err, base_err;
    logic [2:0]       first_new;

    always_comb begin
        req      = bus.tgt_cyc_o & bus.tgt_stb_o & ~bus.tgt_stall_i;
        term     = bus.tgt_ack_i | bus.tgt_err_i | bus.tgt_rty_i;
        has      = outst_q != '0;
        at_max   = outst_q == CNT_W'(MAX_OUTST);
        dec      = term & has;
        wd_run   = bus.tgt_cyc_o & has & ~term;
        // we sits in the MSB so the held copy tells whether write data must be stable
        ctl      = {bus.tgt_we_o, bus.tgt_sel_o, bus.tgt_adr_o, bus.tgt_tga_o, bus.tgt_tgc_o};
        wdat     = {bus.tgt_dat_o, bus.tgt_tgd_o};
        new_err[0] = ~bus.tgt_cyc_o & has & ~term;
        new_err[1] = (bus.tgt_ack_i & bus.tgt_err_i) | (bus.tgt_ack_i & bus.tgt_rty_i) |
                     (bus.tgt_err_i & bus.tgt_rty_i);
        new_err[2] = term & ~has;
        new_err[3] = req & ~term & at_max;
        // fires only on the step into TIMEOUT; the counter then holds, so no repeat
        new_err[4] = (TIMEOUT != 0) && wd_run && (wd_q == TO_W'(TIMEOUT - 1));
        new_err[5] = bus.tgt_stb_o & ~bus.tgt_cyc_o;
        new_err[6] = stalled_q & bus.tgt_cyc_o &
                     (~bus.tgt_stb_o | (ctl != ctl_q) | (ctl_q[CTL_W-1] & (wdat != wdat_q)));
        // a full counter still accepts a request when a termination retires one
        outst_d   = ~bus.tgt_cyc_o ? '0 :
                    outst_q + CNT_W'(req & ~(at_max & ~dec)) - CNT_W'(dec);
        wd_d      = (TIMEOUT == 0 || !wd_run) ? '0 :
                    (wd_q == TO_W'(TIMEOUT)) ? wd_q : wd_q + TO_W'(1);
        stalled_d = bus.tgt_cyc_o & bus.tgt_stb_o & bus.tgt_stall_i;
        ctl_d     = stalled_d ? ctl : ctl_q;
        wdat_d    = stalled_d ? wdat : wdat_q;
        first_new = '0;
        for (int i = 6; i >= 0; i--)
            if (new_err[i]) first_new = 3'(i);
        base_err  = clr_i ? '0 : err_q;
        err_d     = base_err | new_err;
        first_d   = (base_err == '0 && new_err != '0) ? first_new : (clr_i ? '0 : first_q);
        err_stb_d = |new_err;
    end

    always_ff @(posedge clk_i) begin
        if (!sync_rst_n_i) begin
            outst_q   <= '0;
            wd_q      <= '0;
            err_q     <= '0;
            err_stb_q <= 1'b0;
            first_q   <= '0;
            stalled_q <= 1'b0;
            ctl_q     <= '0;
            wdat_q    <= '0;
        end else begin
            outst_q   <= outst_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            err_stb_q <= err_stb_d;
            first_q   <= first_d;
            stalled_q <= stalled_d;
            ctl_q     <= ctl_d;
            wdat_q    <= wdat_d;
        end
    end

    assign outst_o     = outst_q;
    assign busy_o      = outst_q != '0;
    assign err_o       = err_q;
    assign err_stb_o   = err_stb_q;
    assign err_first_o = first_q;
endmodule

// File: tb/tb_wb_tgt_chk.sv
// tb_wb_tgt_chk: directed scenarios plus randomized traffic against a behavioural model.
module tb_wb_tgt_chk;
    localparam int MAXO = 4;
    localparam int TO   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    wb_tgt_chk_if #(.ADR_WIDTH(16), .DAT_WIDTH(16), .SEL_WIDTH(2),
                    .TGA_WIDTH(1), .TGC_WIDTH(1), .TGWD_WIDTH(1)) bus ();

    logic [2:0] outst;
    logic       busy;
    logic [6:0] err;
    logic       err_stb;
    logic [2:0] first;

    wb_tgt_chk #(.MAX_OUTST(MAXO), .TIMEOUT(TO)) dut (
        .clk_i(clk), .sync_rst_n_i(rst_n), .clr_i(clr), .bus(bus),
        .outst_o(outst), .busy_o(busy), .err_o(err), .err_stb_o(err_stb), .err_first_o(first)
    );

    int tests = 0;
    int fails = 0;

    int       m_outst = 0;
    int       m_wd = 0;
    int       m_first = 0;
    bit [6:0] m_err = '0;
    bit       m_stb = 1'b0;
    bit       m_stalled = 1'b0;
    bit       h_we = 1'b0;
    bit [1:0] h_sel = '0;
    bit [15:0] h_adr = '0;
    bit [15:0] h_dat = '0;
    bit       h_tga = 1'b0, h_tgc = 1'b0, h_tgd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: apply the checker's rules to the inputs present at this edge.
    task automatic model_edge();
        bit [6:0] nv;
        int nterm, n;
        bit cyc, stb, term, req;
        if (!rst_n) begin
            m_outst = 0; m_wd = 0; m_first = 0; m_err = '0; m_stb = 1'b0; m_stalled = 1'b0;
            h_we = 1'b0; h_sel = '0; h_adr = '0; h_dat = '0; h_tga = 1'b0; h_tgc = 1'b0; h_tgd = 1'b0;
            return;
        end
        cyc   = bus.tgt_cyc_o;
        stb   = bus.tgt_stb_o;
        nterm = int'(bus.tgt_ack_i) + int'(bus.tgt_err_i) + int'(bus.tgt_rty_i);
        term  = nterm > 0;
        req   = cyc && stb && !bus.tgt_stall_i;
        nv = '0;
        if (!cyc && m_outst > 0 && !term) nv[0] = 1'b1;
        if (nterm > 1) nv[1] = 1'b1;
        if (term && m_outst == 0) nv[2] = 1'b1;
        if (req && !term && m_outst == MAXO) nv[3] = 1'b1;
        if (stb && !cyc) nv[5] = 1'b1;
        if (m_stalled && cyc && (!stb || bus.tgt_we_o != h_we || bus.tgt_sel_o != h_sel ||
            bus.tgt_adr_o != h_adr || bus.tgt_tga_o != h_tga || bus.tgt_tgc_o != h_tgc ||
            (h_we && (bus.tgt_dat_o != h_dat || bus.tgt_tgd_o != h_tgd)))) nv[6] = 1'b1;
        if (!cyc || term || m_outst == 0) m_wd = 0;
        else if (m_wd < TO) begin
            m_wd++;
            if (m_wd == TO) nv[4] = 1'b1;
        end
        if (!cyc) m_outst = 0;
        else begin
            n = m_outst + int'(req) - ((term && m_outst > 0) ? 1 : 0);
            m_outst = (n > MAXO) ? MAXO : n;
        end
        m_stalled = cyc && stb && bus.tgt_stall_i;
        if (m_stalled) begin
            h_we = bus.tgt_we_o; h_sel = bus.tgt_sel_o; h_adr = bus.tgt_adr_o; h_dat = bus.tgt_dat_o;
            h_tga = bus.tgt_tga_o; h_tgc = bus.tgt_tgc_o; h_tgd = bus.tgt_tgd_o;
        end
        if (clr) begin m_err = '0; m_first = 0; end
        if (m_err == 0 && nv != 0)
            for (int i = 6; i >= 0; i--) if (nv[i]) m_first = i;
        m_err = m_err | nv;
        m_stb = |nv;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("m_outst", 32'(outst), m_outst);
        chk("m_busy", 32'(busy), 32'(m_outst != 0));
        chk("m_err", 32'(err), 32'(m_err));
        chk("m_err_stb", 32'(err_stb), 32'(m_stb));
        chk("m_first", 32'(first), m_first);
    endtask

    task automatic drv(input bit c, input bit s, input bit st, input bit a, input bit e, input bit r);
        bus.tgt_cyc_o = c; bus.tgt_stb_o = s; bus.tgt_stall_i = st;
        bus.tgt_ack_i = a; bus.tgt_err_i = e; bus.tgt_rty_i = r;
    endtask

    initial begin
        bit rd_stb[5] = '{1, 1, 1, 0, 0};
        bit rd_ack[5] = '{0, 0, 1, 1, 1};
        int rd_exp[5] = '{1, 2, 2, 1, 0};
        int trate;
        bus.tgt_we_o = 1'b0; bus.tgt_sel_o = 2'b11; bus.tgt_adr_o = 16'h0010; bus.tgt_dat_o = '0;
        bus.tgt_tga_o = 1'b0; bus.tgt_tgc_o = 1'b0; bus.tgt_tgd_o = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("rst_outst", 32'(outst), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_first", 32'(first), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drv(1, rd_stb[i], 0, rd_ack[i], 0, 0);
            tick();
            chk("rd_outst", 32'(outst), rd_exp[i]);
        end
        chk("rd_err", 32'(err), 0);
        drv(0, 0, 0, 0, 0, 0); tick();
        drv(1, 1, 0, 0, 0, 0);
        repeat (4) tick();
        chk("ovf_pre", 32'(err), 0);
        tick();
        chk("ovf_err", 32'(err), 32'h08);
        chk("ovf_stb", 32'(err_stb), 1);
        chk("ovf_outst", 32'(outst), 4);
        chk("ovf_first", 32'(first), 3);
        drv(1, 0, 0, 1, 0, 0); tick();
        chk("ovf_stb_end", 32'(err_stb), 0);
        repeat (3) tick();
        chk("ovf_drain", 32'(outst), 0);
        clr = 1'b1; drv(1, 1, 0, 0, 0, 0); tick(); clr = 1'b0; tick();
        chk("drop_pre", 32'(outst), 2);
        drv(0, 0, 0, 0, 0, 0); tick();
        chk("drop_err", 32'(err), 32'h01);
        chk("drop_outst", 32'(outst), 0);
        drv(1, 1, 0, 0, 0, 0); tick();
        drv(1, 0, 0, 1, 1, 0); tick();
        chk("multi_err", 32'(err), 32'h03);
        chk("multi_first", 32'(first), 0);
        drv(0, 0, 0, 0, 0, 0); tick();
        clr = 1'b1; drv(1, 1, 0, 0, 0, 0); tick(); clr = 1'b0;
        drv(1, 0, 0, 0, 0, 0);
        repeat (7) tick();
        chk("to_early", 32'(err), 0);
        tick();
        chk("to_err", 32'(err), 32'h10);
        chk("to_stb", 32'(err_stb), 1);
        chk("to_first", 32'(first), 4);
        tick();
        chk("to_once", 32'(err_stb), 0);
        drv(1, 0, 0, 1, 0, 0); tick();
        drv(1, 1, 0, 0, 0, 0); tick();
        drv(1, 0, 0, 0, 0, 0);
        repeat (8) tick();
        chk("to_rearm", 32'(err_stb), 1);
        drv(1, 0, 0, 1, 0, 0); tick();
        drv(0, 0, 0, 0, 0, 0); clr = 1'b1; tick(); clr = 1'b0;
        bus.tgt_adr_o = 16'h0010; drv(1, 1, 1, 0, 0, 0); tick();
        bus.tgt_adr_o = 16'h0014; tick();
        chk("hold_err", 32'(err), 32'h40);
        chk("hold_first", 32'(first), 6);
        drv(0, 0, 0, 0, 0, 0); clr = 1'b1; tick(); clr = 1'b0;
        chk("hold_clr", 32'(err), 0);
        bus.tgt_adr_o = 16'h0010; drv(1, 1, 1, 0, 0, 0); tick(); tick();
        drv(1, 1, 0, 0, 0, 0); tick();
        chk("hold_ok", 32'(err), 0);
        chk("hold_req", 32'(outst), 1);
        drv(1, 0, 0, 1, 0, 0); tick();
        tick();
        chk("spur_err", 32'(err), 32'h04);
        clr = 1'b1; drv(0, 1, 0, 0, 0, 0); tick(); clr = 1'b0;
        chk("clr_win_err", 32'(err), 32'h20);
        chk("clr_win_first", 32'(first), 5);
        drv(1, 1, 0, 0, 0, 0); tick(); tick();
        chk("burst_outst", 32'(outst), 2);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("mrst_outst", 32'(outst), 0);
        chk("mrst_err", 32'(err), 0);
        chk("mrst_first", 32'(first), 0);
        chk("mrst_busy", 32'(busy), 0);
        for (int i = 0; i < 800; i++) begin
            trate = ((i / 100) % 2 == 0) ? 3 : 25;
            rst_n = $urandom_range(0, 199) != 0;
            clr   = $urandom_range(0, 15) == 0;
            bus.tgt_cyc_o   = $urandom_range(0, 11) != 0;
            bus.tgt_stb_o   = $urandom_range(0, 1) != 0;
            bus.tgt_stall_i = $urandom_range(0, 3) == 0;
            bus.tgt_ack_i   = $urandom_range(0, trate - 1) == 0;
            bus.tgt_err_i   = $urandom_range(0, 4 * trate) == 0;
            bus.tgt_rty_i   = $urandom_range(0, 4 * trate) == 0;
            bus.tgt_we_o    = $urandom_range(0, 5) == 0 ? ~bus.tgt_we_o : bus.tgt_we_o;
            bus.tgt_adr_o   = $urandom_range(0, 5) == 0 ? 16'h0014 : 16'h0010;
            bus.tgt_sel_o   = $urandom_range(0, 7) == 0 ? 2'b01 : 2'b11;
            bus.tgt_dat_o   = $urandom_range(0, 5) == 0 ? 16'h5555 : 16'hAAAA;
            bus.tgt_tga_o   = 1'($urandom_range(0, 9) == 0);
            bus.tgt_tgc_o   = 1'($urandom_range(0, 9) == 0);
            bus.tgt_tgd_o   = 1'($urandom_range(0, 9) == 0);
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
